// File: rtl/bram_writeback_buffer_if.sv
// Core-to-buffer write-back handshake plus the BRAM port B write side.
interface bram_writeback_buffer_if #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
);
   logic              WBEN;
   logic [ADDR_W-1:0] WBADDR;
   logic [DATA_W-1:0] WBVALUE;
   logic              WBREADY;
   logic              BRAM_GNT;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] dinb;
   logic              enb;
   logic [3:0]        web;

   modport master (
      output WBEN, WBADDR, WBVALUE, BRAM_GNT,
      input  WBREADY, addrb, dinb, enb, web
   );

   modport slave (
      input  WBEN, WBADDR, WBVALUE, BRAM_GNT,
      output WBREADY, addrb, dinb, enb, web
   );
endinterface

// File: rtl/bram_writeback_buffer.sv
// Buffers core result writes in a FIFO and drains them to BRAM port B; push-to-port latency 2 edges.
// Backpressure: WBREADY drops when the FIFO is full; BRAM_GNT low stalls draining without loss.
module bram_writeback_buffer #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 13,
   parameter int DATA_W = 32
) (
   input  logic                   CLK,
   input  logic                   RSTN,
   input  logic                   START_SIGNAL,
   input  logic                   STOP_SIGNAL,
   bram_writeback_buffer_if.slave bus,
   output logic                   DRAIN_DONE,
   output logic                   OVERFLOW,
   output logic                   ADDR_ERR,
   output logic [15:0]            WR_COUNT
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

   // Only in-range addresses are stored, so the two top bits are always zero.
   typedef struct packed {
      logic [ADDR_W-3:0] addr;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   state_t        state;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          addr_ok;
   logic          push_acc;
   logic          store;
   logic          pop;
   logic          enter_active;

   assign bus.WBREADY  = (state == ACTIVE) && (count != CW'(DEPTH));
   assign addr_ok      = (bus.WBADDR[ADDR_W-1 -: 2] == 2'b00);
   assign push_acc     = bus.WBEN && bus.WBREADY;
   assign store        = push_acc && addr_ok;
   assign pop          = (count != '0) && bus.BRAM_GNT && ((state == ACTIVE) || (state == DRAIN));
   assign enter_active = START_SIGNAL && ((state == IDLE) || (state == DONE));
   assign head         = mem[rd_ptr];

   always_ff @(posedge CLK) begin
      if (store) begin
         mem[wr_ptr] <= '{addr: bus.WBADDR[ADDR_W-3:0], data: bus.WBVALUE};
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state      <= IDLE;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         bus.addrb  <= '0;
         bus.dinb   <= '0;
         bus.enb    <= 1'b0;
         bus.web    <= 4'h0;
         DRAIN_DONE <= 1'b0;
         OVERFLOW   <= 1'b0;
         ADDR_ERR   <= 1'b0;
         WR_COUNT   <= '0;
      end else begin
         case (state)
            IDLE:    if (START_SIGNAL) state <= ACTIVE;
            ACTIVE:  if (STOP_SIGNAL) state <= DRAIN;
            DRAIN:   if ((count == '0) && !bus.enb) state <= DONE;
            DONE:    if (START_SIGNAL) state <= ACTIVE;
            default: state <= IDLE;
         endcase

         if (store) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         case ({store, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         // addrb/dinb keep their last values between writes.
         bus.enb <= pop;
         bus.web <= pop ? 4'hF : 4'h0;
         if (pop) begin
            bus.addrb <= {head.addr, 2'b00};
            bus.dinb  <= head.data;
         end

         if (enter_active) begin
            DRAIN_DONE <= 1'b0;
            OVERFLOW   <= 1'b0;
            ADDR_ERR   <= 1'b0;
            WR_COUNT   <= '0;
         end else begin
            if ((state == DRAIN) && (count == '0) && !bus.enb) DRAIN_DONE <= 1'b1;
            if ((state == ACTIVE) && bus.WBEN && !bus.WBREADY) OVERFLOW <= 1'b1;
            if (push_acc && !addr_ok) ADDR_ERR <= 1'b1;
            if (bus.enb && (WR_COUNT != 16'hFFFF)) WR_COUNT <= WR_COUNT + 16'd1;
         end
      end
   end
endmodule

// File: tb/tb_bram_writeback_buffer.sv
// Randomized bench for bram_writeback_buffer with a queue-based reference model checked every cycle.
module tb_bram_writeback_buffer;
   localparam int DEPTH  = 8;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 32;

   logic        CLK = 1'b0;
   logic        RSTN = 1'b1;
   logic        START_SIGNAL = 1'b0;
   logic        STOP_SIGNAL = 1'b0;
   logic        DRAIN_DONE;
   logic        OVERFLOW;
   logic        ADDR_ERR;
   logic [15:0] WR_COUNT;

   bram_writeback_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   bram_writeback_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .CLK(CLK), .RSTN(RSTN), .START_SIGNAL(START_SIGNAL), .STOP_SIGNAL(STOP_SIGNAL),
      .bus(bus), .DRAIN_DONE(DRAIN_DONE), .OVERFLOW(OVERFLOW), .ADDR_ERR(ADDR_ERR),
      .WR_COUNT(WR_COUNT)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: run phase, a plain queue of pending writes, and the expected port/flag values.
   typedef struct { logic [12:0] a; logic [31:0] d; } ent_t;
   localparam int P_IDLE = 0, P_ACT = 1, P_DRN = 2, P_DONE = 3;
   ent_t        q[$];
   ent_t        e;
   int          ph = P_IDLE;
   logic        m_enb = 1'b0;
   logic [12:0] m_addrb = '0;
   logic [31:0] m_dinb = '0;
   int          m_wr = 0;
   bit          m_ovf = 0, m_aerr = 0, m_done = 0;
   int          old_sz;
   bit          old_enb, rdy;

   always @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         q.delete();
         ph = P_IDLE; m_enb = 0; m_addrb = '0; m_dinb = '0;
         m_wr = 0; m_ovf = 0; m_aerr = 0; m_done = 0;
      end else begin
         old_sz  = q.size();
         old_enb = m_enb;
         rdy     = (ph == P_ACT) && (old_sz < DEPTH);
         if (old_enb && m_wr < 65535) m_wr++;
         if (old_sz > 0 && bus.BRAM_GNT && (ph == P_ACT || ph == P_DRN)) begin
            e = q.pop_front();
            m_enb = 1; m_addrb = 13'(e.a * 13'd4); m_dinb = e.d;
         end else begin
            m_enb = 0;
         end
         if (bus.WBEN && rdy) begin
            if (bus.WBADDR < 13'd2048) q.push_back('{bus.WBADDR, bus.WBVALUE});
            else m_aerr = 1;
         end
         if (ph == P_ACT && bus.WBEN && !rdy) m_ovf = 1;
         case (ph)
            P_IDLE, P_DONE: if (START_SIGNAL) begin
               ph = P_ACT; m_wr = 0; m_ovf = 0; m_aerr = 0; m_done = 0;
            end
            P_ACT: if (STOP_SIGNAL) ph = P_DRN;
            P_DRN: if (old_sz == 0 && !old_enb) begin ph = P_DONE; m_done = 1; end
            default: ;
         endcase
      end
   end

   logic [12:0] log_a[$];
   logic [31:0] log_d[$];

   always @(negedge CLK) begin
      check("outputs_vs_model",
            {bus.WBREADY, bus.enb, bus.web, bus.addrb, bus.dinb, DRAIN_DONE, OVERFLOW, ADDR_ERR, WR_COUNT},
            {(ph == P_ACT) && (q.size() < DEPTH), m_enb, m_enb ? 4'hF : 4'h0, m_addrb, m_dinb,
             m_done, m_ovf, m_aerr, 16'(m_wr)});
      if (bus.enb === 1'b1) begin
         log_a.push_back(bus.addrb);
         log_d.push_back(bus.dinb);
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic pulse_start();
      START_SIGNAL = 1'b1; tick(); START_SIGNAL = 1'b0;
   endtask

   task automatic pulse_stop();
      STOP_SIGNAL = 1'b1; tick(); STOP_SIGNAL = 1'b0;
   endtask

   task automatic push(input logic [12:0] a, input logic [31:0] d);
      bus.WBEN = 1'b1; bus.WBADDR = a; bus.WBVALUE = d;
      tick();
      bus.WBEN = 1'b0;
   endtask

   task automatic wait_done(input int budget, input bit rand_gnt);
      int k = 0;
      while (DRAIN_DONE !== 1'b1 && k < budget) begin
         if (rand_gnt) bus.BRAM_GNT = ($urandom_range(0, 1) == 1);
         tick();
         k++;
      end
      bus.BRAM_GNT = 1'b1;
      check("drain_done_reached", DRAIN_DONE, 1'b1);
   endtask

   task automatic clear_log();
      log_a.delete();
      log_d.delete();
   endtask

   logic [31:0] exp_d[8];
   int          accepted;

   initial begin
      bus.WBEN = 1'b0; bus.WBADDR = '0; bus.WBVALUE = '0; bus.BRAM_GNT = 1'b0;
      #1 RSTN = 1'b0;
      repeat (3) tick();
      check("reset_outputs",
            {bus.WBREADY, bus.enb, bus.web, bus.addrb, bus.dinb, DRAIN_DONE, OVERFLOW, ADDR_ERR, WR_COUNT}, '0);
      RSTN = 1'b1;
      tick();

      // Basic run: three writes, check two-edge latency and order.
      bus.BRAM_GNT = 1'b1;
      clear_log();
      pulse_start();
      push(13'd0, 32'hA0);
      @(negedge CLK);
      check("latency_not_yet", bus.enb, 1'b0);
      @(negedge CLK);
      check("latency_first_write", {bus.enb, bus.web, bus.addrb, bus.dinb}, {1'b1, 4'hF, 13'h000, 32'hA0});
      push(13'd1, 32'hA1);
      push(13'd2, 32'hA2);
      pulse_stop();
      wait_done(50, 0);
      check("run1_wr_count", WR_COUNT, 16'd3);
      check("run1_n_writes", log_a.size(), 3);
      if (log_a.size() == 3) begin
         check("run1_addrs", {log_a[0], log_a[1], log_a[2]}, {13'h000, 13'h004, 13'h008});
         check("run1_data", {log_d[0], log_d[1], log_d[2]}, {32'hA0, 32'hA1, 32'hA2});
      end

      // Fill with grant withheld, then overflow on the ninth offer.
      clear_log();
      pulse_start();
      bus.BRAM_GNT = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_d[i] = $urandom;
         push(13'(10 + i), exp_d[i]);
      end
      check("full_not_ready", bus.WBREADY, 1'b0);
      push(13'd18, 32'hDEAD_BEEF);
      check("overflow_set", OVERFLOW, 1'b1);
      bus.BRAM_GNT = 1'b1;
      pulse_stop();
      wait_done(60, 0);
      check("ovf_n_writes", log_a.size(), 8);
      check("ovf_wr_count", WR_COUNT, 16'd8);
      if (log_a.size() == 8)
         for (int i = 0; i < 8; i++) begin
            check("ovf_order_addr", log_a[i], 13'((10 + i) * 4));
            check("ovf_order_data", log_d[i], exp_d[i]);
         end

      // Streaming at full occupancy: core pushes whenever ready.
      clear_log();
      pulse_start();
      bus.BRAM_GNT = 1'b0;
      for (int i = 0; i < 8; i++) push(13'(100 + i), $urandom);
      bus.BRAM_GNT = 1'b1;
      accepted = 0;
      repeat (20) begin
         bus.WBEN = bus.WBREADY; bus.WBADDR = 13'($urandom_range(0, 2047)); bus.WBVALUE = $urandom;
         if (bus.WBREADY) accepted++;
         tick();
      end
      bus.WBEN = 1'b0;
      check("stream_no_overflow", OVERFLOW, 1'b0);
      pulse_stop();
      wait_done(60, 0);
      check("stream_n_writes", log_a.size(), 8 + accepted);

      // Out-of-range address is consumed and flagged; the next valid write lands.
      clear_log();
      pulse_start();
      push(13'h1800, 32'h1111_1111);
      push(13'h0005, 32'h2222_2222);
      pulse_stop();
      wait_done(50, 0);
      check("addr_err_set", ADDR_ERR, 1'b1);
      check("addr_err_n_writes", log_a.size(), 1);
      if (log_a.size() == 1) check("addr_err_valid_write", {log_a[0], log_d[0]}, {13'h014, 32'h2222_2222});

      // Second START from DONE clears everything; a run of two writes counts two.
      pulse_start();
      check("restart_clears", {DRAIN_DONE, OVERFLOW, ADDR_ERR, WR_COUNT}, '0);
      push(13'd7, $urandom);
      push(13'd8, $urandom);
      pulse_stop();
      wait_done(50, 0);
      check("run2_wr_count", WR_COUNT, 16'd2);

      // Reset in DRAIN with entries pending: nothing may reach BRAM afterwards.
      pulse_start();
      bus.BRAM_GNT = 1'b0;
      for (int i = 0; i < 5; i++) push(13'(200 + i), $urandom);
      pulse_stop();
      repeat (3) tick();
      #2 RSTN = 1'b0;
      #1;
      check("async_reset_outputs",
            {bus.WBREADY, bus.enb, bus.web, bus.addrb, bus.dinb, DRAIN_DONE, OVERFLOW, ADDR_ERR, WR_COUNT}, '0);
      clear_log();
      repeat (3) tick();
      RSTN = 1'b1;
      bus.BRAM_GNT = 1'b1;
      repeat (20) tick();
      check("no_write_after_reset", log_a.size(), 0);

      // Randomized runs: random offers, stray STARTs, out-of-range addresses, grant jitter.
      repeat (6) begin
         pulse_start();
         repeat (40 + $urandom_range(0, 40)) begin
            bus.WBEN     = ($urandom_range(0, 1) == 1);
            bus.WBADDR   = ($urandom_range(0, 7) == 0) ? (13'($urandom) | 13'h0800)
                                                       : 13'($urandom_range(0, 2047));
            bus.WBVALUE  = $urandom;
            bus.BRAM_GNT = ($urandom_range(0, 9) < 7);
            START_SIGNAL = ($urandom_range(0, 24) == 0);
            tick();
         end
         bus.WBEN = 1'b0;
         START_SIGNAL = 1'b0;
         pulse_stop();
         wait_done(300, 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
